fod_phase_monitor: RTL and testbench
====================================

# fod_phase_monitor

Synthesizable phase-error monitor for the FOD loop. It samples an NPH-phase interleaved auxiliary clock (FMP) on each edge of the FOD output clock and decodes the sampled thermometer word into a phase index. It then unwraps the phase into a signed accumulated drift and measures drift per window to assert a lock flag. It sits between the FOD analog path (clocked by FDTC) and FOD_CTRL calibration logic. It generalises the 8-phase sampler/decoder to any power-of-two phase count, and adds bubble detection, unwrapping, windowed drift and lock detection.

## Interface
- NPH, 8: number of interleaved phases; power of two, ≥4. PW = clog2(NPH).
- WACC, 16: width of signed accumulators ACC and WIN_DRIFT.
- WIN, 6: window length is 2^WIN processed samples.
- LOCK_TH, 2: max |WIN_DRIFT| for a good window.
- LOCK_CNT, 4: consecutive good windows required for LOCK.
- CLK  in  1  FOD output clock (FDTC); all logic is on its rising edge.
- NARST  in  1  asynchronous active-low reset.
- EN  in  1  sample enable; low freezes all state.
- CLR  in  1  synchronous clear of tracking state.
- FMP  in  NPH  multiphase clock bus; bit i is phase i·360°/NPH.
- PHE  out  PW  decoded phase index.
- PHE_VLD  out  1  one-cycle pulse: PHE updated by a valid code.
- PHE_ERR  out  1  one-cycle pulse: sampled code invalid.
- DPHE  out  PW+1 signed  wrapped phase step, range [−NPH/2, NPH/2−1].
- ACC  out  WACC signed  cumulative unwrapped phase.
- WIN_DRIFT  out  WACC signed  sum of DPHE over the last completed window.
- WIN_VLD  out  1  one-cycle pulse: WIN_DRIFT updated.
- LOCK  out  1  lock indicator.

## Operation
- Stage S1: PSAMP ← FMP when EN=1. A valid bit s1v ← EN.
- Decode: PHE = i such that PSAMP[i]=1 and PSAMP[(i+1) mod NPH]=0. Example: 8'bxxxx_xx01 gives 0; 8'b1xxx_xxx0 gives 7.
- A code is valid only with exactly one such i. All-0, all-1, or more than one 1→0 transition is an error.
- Stage S2, when s1v:
  - Valid code: PHE registers the index and PHE_VLD pulses.
  - Error: PHE holds its value, PHE_ERR pulses, and the window error flag werr is set.
- Stage S3, on a valid S2 sample: DPHE = (PHE_new − PHE_prev) mod NPH, mapped into [−NPH/2, NPH/2−1]. ACC += DPHE, with two's-complement wrap.
- The first valid sample after reset or CLR has no reference. Its DPHE is 0 and it stores the reference.
- On an error sample: DPHE=0, ACC holds, and the reference is unchanged.
- Window: the counter increments on every S2 sample (valid or error). The window sum wsum += DPHE and saturates at the signed WACC limits.
- Window end (2^WIN-th sample):
  - WIN_DRIFT ← wsum including this sample, and WIN_VLD pulses.
  - wsum, the counter, and werr restart at 0.
  - Good window means |WIN_DRIFT| ≤ LOCK_TH and werr=0. A good window increments the lock counter, saturating at LOCK_CNT. Otherwise the counter resets to 0 and LOCK deasserts in the same cycle.
  - LOCK=1 when the counter equals LOCK_CNT.
- EN=0: no new samples enter. Samples already in S2/S3 complete. Counters and outputs hold, and pulses are 0.
- CLR=1: clears ACC, wsum, window count, werr, lock counter, LOCK, and the reference-present flag. It flushes S2/S3 valid bits and beats any concurrent sample. PHE and WIN_DRIFT hold.

## Timing
- FMP sampled at edge k gives PHE/PHE_VLD/PHE_ERR after edge k+1, and DPHE/ACC/window/LOCK after edge k+2.
- Throughput is one sample per cycle. WIN_VLD and LOCK change on the same edge.
- NARST low clears all registers immediately. Every output resets to 0, including LOCK. The first sample after release becomes the reference sample.

## Structure
- Shared package fod_pkg holds the phase-index and signed-delta typedefs, the wrap function for mod-NPH deltas, and the saturating-add function.
- One combinational sub-module, fod_therm_decode, maps NPH bits to index plus a valid flag. It is parametrised by NPH.

## Test plan
- Constant FMP=8'b0000_1111: PHE=3, DPHE=0, WIN_DRIFT=0 every 64 samples. LOCK rises with the 4th WIN_VLD.
- Code rotates +1 phase per cycle: DPHE=+1, WIN_DRIFT=64, LOCK stays 0. Reversing rotation gives DPHE=−1 and WIN_DRIFT=−64.
- Wrap cases: PHE 7→0 gives DPHE=+1, 0→7 gives −1, 3→7 gives −4. With WACC=8 and steady +1, ACC goes 127→−128.
- Bubble 8'b0101_0011 injected once while locked: PHE_ERR pulses and PHE holds. That window's WIN_VLD clears LOCK, and relock takes 4 further good windows.
- CLR at mid-window sample 30: the next window takes a full 64 samples, the first post-CLR DPHE=0, and ACC=0.
- NARST asserted mid-window while LOCK=1: all outputs are 0 immediately. EN toggled low for 10 cycles: counts hold with no pulses, and the window completes 10 cycles later.

Source files
------------

// File: rtl/fod_pkg.sv
// Shared types and arithmetic helpers for the FOD phase monitor.
package fod_pkg;
  localparam int NPH_DEF = 8;
  localparam int PW_DEF  = $clog2(NPH_DEF);

  typedef logic [PW_DEF-1:0]      phase_idx_t;
  typedef logic signed [PW_DEF:0] phase_dlt_t;

  // Folds a raw index difference into [-nph/2, nph/2-1]; nph is a power of two.
  function automatic int wrap_delta(input int diff, input int nph);
    int m;
    m = diff & (nph - 1);
    return (m >= nph / 2) ? m - nph : m;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint hi, lo, s;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction
endpackage

// File: rtl/fod_therm_decode.sv
// Thermometer-to-index decoder: finds the single high-to-low phase boundary.
module fod_therm_decode #(
  parameter int NPH = 8
) (
  input  logic [NPH-1:0]         code_i,
  output logic [$clog2(NPH)-1:0] idx_o,
  output logic                   valid_o
);
  localparam int PW = $clog2(NPH);

  logic [NPH-1:0] edge_w;
  logic           hit, dup;

  always_comb begin
    for (int i = 0; i < NPH; i++) edge_w[i] = code_i[i] & ~code_i[(i + 1) % NPH];
  end

  // Any second boundary (bubble), or none at all, makes the code unusable.
  always_comb begin
    idx_o = '0;
    hit   = 1'b0;
    dup   = 1'b0;
    for (int i = 0; i < NPH; i++) begin
      if (edge_w[i]) begin
        dup   = dup | hit;
        hit   = 1'b1;
        idx_o = PW'(i);
      end
    end
    valid_o = hit & ~dup;
  end
endmodule

// File: rtl/fod_phase_monitor.sv
// Samples the multiphase FMP bus, decodes phase, unwraps it into drift and
// judges per-window drift to produce a lock flag.
module fod_phase_monitor
  import fod_pkg::*;
#(
  parameter int NPH      = 8,
  parameter int WACC     = 16,
  parameter int WIN      = 6,
  parameter int LOCK_TH  = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [NPH-1:0]            fmp_i,
  output logic [$clog2(NPH)-1:0]    phe_o,
  output logic                      phe_vld_o,
  output logic                      phe_err_o,
  output logic signed [$clog2(NPH):0] dphe_o,
  output logic signed [WACC-1:0]    acc_o,
  output logic signed [WACC-1:0]    win_drift_o,
  output logic                      win_vld_o,
  output logic                      lock_o
);
  localparam int PW  = $clog2(NPH);
  localparam int LCW = $clog2(LOCK_CNT + 1);

  logic [NPH-1:0]        psamp_q;
  logic                  s1v_q;
  logic [PW-1:0]         dec_idx;
  logic                  dec_ok;

  logic [PW-1:0]         phe_q;
  logic                  phe_vld_q, phe_err_q, s2v_q, s2ok_q;

  logic [PW-1:0]         ref_q, ref_d;
  logic                  have_ref_q, have_ref_d;
  logic signed [PW:0]    dphe_q, dphe_d, dlt;
  logic signed [WACC-1:0] acc_q, acc_d, wsum_q, wsum_d, wsum_nx;
  logic signed [WACC-1:0] wdrift_q, wdrift_d;
  logic [WIN-1:0]        wcnt_q, wcnt_d;
  logic                  werr_q, werr_d, werr_nx;
  logic                  wvld_q, wvld_d;
  logic [LCW-1:0]        lcnt_q, lcnt_d;
  logic                  lock_q, lock_d;
  logic                  good;

  fod_therm_decode #(.NPH(NPH)) u_dec (
    .code_i  (psamp_q),
    .idx_o   (dec_idx),
    .valid_o (dec_ok)
  );

  // S1 sample and S2 decode register; CLR drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psamp_q   <= '0;
      s1v_q     <= 1'b0;
      phe_q     <= '0;
      phe_vld_q <= 1'b0;
      phe_err_q <= 1'b0;
      s2v_q     <= 1'b0;
      s2ok_q    <= 1'b0;
    end else begin
      if (en_i) psamp_q <= fmp_i;
      s1v_q     <= en_i & ~clr_i;
      s2v_q     <= s1v_q & ~clr_i;
      s2ok_q    <= dec_ok;
      phe_vld_q <= 1'b0;
      phe_err_q <= 1'b0;
      if (s1v_q && !clr_i) begin
        if (dec_ok) begin
          phe_q     <= dec_idx;
          phe_vld_q <= 1'b1;
        end else begin
          phe_err_q <= 1'b1;
        end
      end
    end
  end

  // S3: unwrap, accumulate and window bookkeeping.
  always_comb begin
    dlt = '0;
    if (s2ok_q && have_ref_q)
      dlt = (PW+1)'(wrap_delta(int'(phe_q) - int'(ref_q), NPH));
    wsum_nx = WACC'(sat_add(longint'(wsum_q), longint'(dlt), WACC));
    werr_nx = werr_q | ~s2ok_q;
    good    = (int'(wsum_nx) <= LOCK_TH) && (int'(wsum_nx) >= -LOCK_TH) && !werr_nx;

    ref_d      = ref_q;
    have_ref_d = have_ref_q;
    dphe_d     = dphe_q;
    acc_d      = acc_q;
    wsum_d     = wsum_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    wdrift_d   = wdrift_q;
    wvld_d     = 1'b0;
    lcnt_d     = lcnt_q;
    lock_d     = lock_q;

    if (clr_i) begin
      have_ref_d = 1'b0;
      dphe_d     = '0;
      acc_d      = '0;
      wsum_d     = '0;
      wcnt_d     = '0;
      werr_d     = 1'b0;
      lcnt_d     = '0;
      lock_d     = 1'b0;
    end else if (s2v_q) begin
      dphe_d = dlt;
      if (s2ok_q) begin
        ref_d      = phe_q;
        have_ref_d = 1'b1;
        acc_d      = acc_q + WACC'(dlt);
      end
      if (&wcnt_q) begin
        wdrift_d = wsum_nx;
        wvld_d   = 1'b1;
        wsum_d   = '0;
        wcnt_d   = '0;
        werr_d   = 1'b0;
        if (!good)                           lcnt_d = '0;
        else if (lcnt_q != LCW'(LOCK_CNT))   lcnt_d = lcnt_q + LCW'(1);
        lock_d = (lcnt_d == LCW'(LOCK_CNT));
      end else begin
        wsum_d = wsum_nx;
        wcnt_d = wcnt_q + WIN'(1);
        werr_d = werr_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q      <= '0;
      have_ref_q <= 1'b0;
      dphe_q     <= '0;
      acc_q      <= '0;
      wsum_q     <= '0;
      wcnt_q     <= '0;
      werr_q     <= 1'b0;
      wdrift_q   <= '0;
      wvld_q     <= 1'b0;
      lcnt_q     <= '0;
      lock_q     <= 1'b0;
    end else begin
      ref_q      <= ref_d;
      have_ref_q <= have_ref_d;
      dphe_q     <= dphe_d;
      acc_q      <= acc_d;
      wsum_q     <= wsum_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      wdrift_q   <= wdrift_d;
      wvld_q     <= wvld_d;
      lcnt_q     <= lcnt_d;
      lock_q     <= lock_d;
    end
  end

  assign phe_o       = phe_q;
  assign phe_vld_o   = phe_vld_q;
  assign phe_err_o   = phe_err_q;
  assign dphe_o      = dphe_q;
  assign acc_o       = acc_q;
  assign win_drift_o = wdrift_q;
  assign win_vld_o   = wvld_q;
  assign lock_o      = lock_q;
endmodule

// File: tb/tb_fod_phase_monitor.sv
// Directed bench for fod_phase_monitor: decode/unwrap vector table plus
// window, lock, CLR, reset and enable sequences.
module tb_fod_phase_monitor;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, clr = 1'b0;
  logic [7:0] fmp = '0;

  logic [2:0] phe, phe8;
  logic phe_vld, phe_err, wvld, lock, phe_vld8, phe_err8, wvld8, lock8;
  logic signed [3:0] dphe, dphe8;
  logic signed [15:0] acc, wdr;
  logic signed [7:0] acc8, wdr8;

  fod_phase_monitor #(.NPH(8), .WACC(16), .WIN(6), .LOCK_TH(2), .LOCK_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .fmp_i(fmp),
    .phe_o(phe), .phe_vld_o(phe_vld), .phe_err_o(phe_err), .dphe_o(dphe),
    .acc_o(acc), .win_drift_o(wdr), .win_vld_o(wvld), .lock_o(lock));

  fod_phase_monitor #(.NPH(8), .WACC(8), .WIN(6), .LOCK_TH(2), .LOCK_CNT(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .fmp_i(fmp),
    .phe_o(phe8), .phe_vld_o(phe_vld8), .phe_err_o(phe_err8), .dphe_o(dphe8),
    .acc_o(acc8), .win_drift_o(wdr8), .win_vld_o(wvld8), .lock_o(lock8));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int p, ncyc, errs;
  int wq[$], cq[$], lq[$], w8q[$], errphe[$], acc8h[$];

  typedef struct {
    logic [7:0] f;
    int phe; int vld; int err; int dphe; int acc;
  } vec_t;
  vec_t tab[15];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] code_of(input int ph);
    logic [7:0] c;
    c = '0;
    for (int b = 0; b < 4; b++) c[(ph - b) & 7] = 1'b1;
    return c;
  endfunction

  task automatic clear_obs();
    ncyc = 0; errs = 0;
    wq.delete(); cq.delete(); lq.delete(); w8q.delete(); errphe.delete(); acc8h.delete();
  endtask

  task automatic tick(input logic [7:0] f, input logic e, input logic c);
    fmp = f; en = e; clr = c;
    @(posedge clk); #1;
    ncyc++;
    if (wvld) begin
      wq.push_back(int'(wdr)); cq.push_back(ncyc);
      lq.push_back(int'(lock)); w8q.push_back(int'(wdr8));
    end
    if (phe_err) begin errs++; errphe.push_back(int'(phe)); end
    acc8h.push_back(int'(acc8));
  endtask

  task automatic feed(input int n, input int step);
    for (int i = 0; i < n; i++) begin
      tick(code_of(p), 1'b1, 1'b0);
      p = (p + step) & 7;
    end
  endtask

  task automatic flush();
    tick(code_of(p), 1'b0, 1'b0);
    tick(code_of(p), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
  endtask

  initial begin
    int vcnt, ahold;
    bit found;

    // reset state
    #1 rst_n = 1'b0;
    #3;
    chk("rst_phe", phe, 0);   chk("rst_vld", phe_vld, 0); chk("rst_err", phe_err, 0);
    chk("rst_dphe", dphe, 0); chk("rst_acc", acc, 0);     chk("rst_wdr", wdr, 0);
    chk("rst_wvld", wvld, 0); chk("rst_lock", lock, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // decode / unwrap vector table
    tab[0]  = '{code_of(3), 3, 1, 0,  0,  0};
    tab[1]  = '{code_of(3), 3, 1, 0,  0,  0};
    tab[2]  = '{code_of(4), 4, 1, 0,  1,  1};
    tab[3]  = '{code_of(7), 7, 1, 0,  3,  4};
    tab[4]  = '{code_of(0), 0, 1, 0,  1,  5};
    tab[5]  = '{code_of(7), 7, 1, 0, -1,  4};
    tab[6]  = '{code_of(3), 3, 1, 0, -4,  0};
    tab[7]  = '{code_of(7), 7, 1, 0, -4, -4};
    tab[8]  = '{8'h53,      7, 0, 1,  0, -4};
    tab[9]  = '{8'h00,      7, 0, 1,  0, -4};
    tab[10] = '{8'hFF,      7, 0, 1,  0, -4};
    tab[11] = '{code_of(0), 0, 1, 0,  1, -3};
    tab[12] = '{8'h01,      0, 1, 0,  0, -3};
    tab[13] = '{8'h80,      7, 1, 0, -1, -4};
    tab[14] = '{code_of(2), 2, 1, 0,  3, -1};
    clear_obs();
    for (int i = 0; i <= 16; i++) begin
      if (i < 15) tick(tab[i].f, 1'b1, 1'b0);
      else        tick(8'h0F, 1'b0, 1'b0);
      if (i >= 1 && i <= 15) begin
        chk($sformatf("tab%0d_phe", i-1), phe, tab[i-1].phe);
        chk($sformatf("tab%0d_vld", i-1), phe_vld, tab[i-1].vld);
        chk($sformatf("tab%0d_err", i-1), phe_err, tab[i-1].err);
      end
      if (i >= 2) begin
        chk($sformatf("tab%0d_dphe", i-2), dphe, tab[i-2].dphe);
        chk($sformatf("tab%0d_acc", i-2), acc, tab[i-2].acc);
      end
    end

    // constant phase: lock on the 4th good window
    do_reset(); p = 3;
    feed(256, 0); flush();
    chk("lk_nwin", wq.size(), 4);
    for (int j = 0; j < 4; j++) if (j < wq.size()) begin
      chk($sformatf("lk_wdr%0d", j), wq[j], 0);
      chk($sformatf("lk_cyc%0d", j), cq[j], 64*(j+1) + 2);
      chk($sformatf("lk_lock%0d", j), lq[j], (j == 3) ? 1 : 0);
    end
    chk("lk_phe", phe, 3);
    chk("lk_lock_end", lock, 1);

    // single bubble while locked: lock lost, relock after 4 more windows
    clear_obs();
    feed(10, 0); tick(8'h53, 1'b1, 1'b0); feed(53, 0); feed(256, 0); flush();
    chk("bub_errs", errs, 1);
    if (errphe.size() > 0) chk("bub_phe_hold", errphe[0], 3);
    chk("bub_nwin", wq.size(), 5);
    for (int j = 0; j < 5; j++) if (j < wq.size()) begin
      chk($sformatf("bub_wdr%0d", j), wq[j], 0);
      chk($sformatf("bub_lock%0d", j), lq[j], (j == 4) ? 1 : 0);
    end

    // rotation: +1, then -1, then +3 (saturates the 8-bit window sum)
    do_reset(); p = 3;
    feed(192, 1);
    p = (p - 2) & 7;
    feed(64, -1);
    p = (p + 4) & 7;
    feed(64, 3); flush();
    chk("rot_nwin", wq.size(), 5);
    if (wq.size() == 5) begin
      chk("rot_w0", wq[0], 63);  chk("rot_w1", wq[1], 64);  chk("rot_w2", wq[2], 64);
      chk("rot_w3", wq[3], -64); chk("rot_w4", wq[4], 192);
      chk("rot_w8_0", w8q[0], 63); chk("rot_w8_4", w8q[4], 127);
      for (int j = 0; j < 5; j++) chk($sformatf("rot_lock%0d", j), lq[j], 0);
    end
    chk("rot_acc", acc, 319);
    found = 1'b0;
    for (int j = 1; j < acc8h.size(); j++)
      if (acc8h[j-1] == 127 && acc8h[j] == -128) found = 1'b1;
    chk("acc8_wrap", found, 1);

    // CLR mid-window at sample 30
    do_reset(); p = 3;
    feed(30, 1);
    tick(code_of(p), 1'b1, 1'b1); p = (p + 1) & 7;
    chk("clr_acc", acc, 0);
    chk("clr_lock", lock, 0);
    clear_obs();
    feed(3, 1);
    chk("clr_first_dphe", dphe, 0);
    chk("clr_first_acc", acc, 0);
    feed(1, 1);
    chk("clr_second_dphe", dphe, 1);
    chk("clr_second_acc", acc, 1);
    feed(60, 1); flush();
    chk("clr_nwin", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("clr_wcyc", cq[0], 66);
      chk("clr_wdr", wq[0], 63);
    end

    // asynchronous reset while locked, mid-window
    do_reset(); p = 3;
    feed(256, 0); flush(); feed(20, 1);
    chk("ar_lock_before", lock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_phe", phe, 0); chk("ar_dphe", dphe, 0); chk("ar_acc", acc, 0);
    chk("ar_lock", lock, 0); chk("ar_vld", phe_vld, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // EN low for 10 cycles mid-window
    do_reset(); p = 3;
    feed(20, 1);
    vcnt = 0; ahold = 0;
    for (int g = 1; g <= 10; g++) begin
      tick(code_of(p), 1'b0, 1'b0);
      if (g >= 2) vcnt += int'(phe_vld) + int'(phe_err) + int'(wvld);
      if (g == 2) ahold = int'(acc);
    end
    chk("en_no_pulse", vcnt, 0);
    chk("en_acc_at_gap", ahold, 19);
    chk("en_acc_hold", acc, 19);
    feed(44, 1); flush();
    chk("en_nwin", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("en_wcyc", cq[0], 76);
      chk("en_wdr", wq[0], 63);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
